multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control FSM for the multicycle RV32I core, the successor to the single-cycle datapath.
- Sequences one instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK using the shared datapath: PC register, instruction register, register unit and ALU.
- Arbitrates a single unified memory port between instruction fetch and load/store through a req/ready handshake.
- Drives all datapath enables and mux selects, counts retired instructions, and traps on illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 16, max wait cycles for mem_ready before a timeout trap (must be >= 1).
- CNT_W, 32, width of the instret and cycle counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- opCode  in  7  instruction[6:0] from the instruction register
- fun3  in  3  instruction[14:12]
- fun7  in  7  instruction[31:25]
- write_reg  in  5  rd field
- branch_taken  in  1  branch comparator result, valid in EXECUTE
- mem_ready  in  1  memory completes the current request
- mem_req  out  1  memory request
- mem_we  out  1  store request
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_wr  out  1  load instruction register
- pc_wr  out  1  update PC
- pc_sel  out  2  0 = PC+4, 1 = PC+imm, 2 = (rs1+imm)&~1
- ru_wr  out  1  register unit write enable (RUWr)
- ru_data_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4
- alu_src_b  out  1  0 = rs2, 1 = immediate
- alu_op  out  2  0 = add, 1 = sub/compare, 2 = decode fun3/fun7, 3 = pass B
- state  out  3  current state encoding
- trap  out  1  sticky trap flag
- trap_cause  out  2  0 = none, 1 = illegal opcode, 2 = fetch timeout, 3 = data timeout
- instret  out  CNT_W  retired instruction count
- cycle_count  out  CNT_W  see Optional Feature

Behaviour:
- Reset (reset == 0, asynchronous): state = FETCH (0). Counters, trap and trap_cause = 0. All strobes (mem_req, ir_wr, pc_wr, ru_wr, mem_we) are 0. Selects = 0.
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=7.
- Strobes are Moore/Mealy combinational from the registered state. No strobe is asserted while reset is low.
- Wait counter: cleared on entry to FETCH/MEMORY, increments each cycle mem_req=1 and mem_ready=0.
- FETCH:
  - mem_req=1, mem_addr_sel=0.
  - On mem_ready: ir_wr=1 for that cycle, go to DECODE.
  - When the wait counter reaches MEM_TIMEOUT with no ready: go to TRAP, cause 2.
- DECODE (1 cycle):
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111. Go to EXECUTE.
  - Any other opcode: go to TRAP, cause 1.
- EXECUTE (1 cycle):
  - R-type: alu_op=2, src_b=0. I-ALU: alu_op=2, src_b=1. Both go to WRITEBACK.
  - LUI: alu_op=3, src_b=1, go to WRITEBACK.
  - AUIPC and LOAD/STORE: alu_op=0, src_b=1. AUIPC goes to WRITEBACK; LOAD/STORE go to MEMORY.
  - BRANCH: alu_op=1. pc_wr=1, pc_sel = branch_taken ? 1 : 0. instret += 1. Go to FETCH.
  - JAL/JALR: go to WRITEBACK with ru_data_sel=2, pc_sel=1 (JAL) or 2 (JALR).
- MEMORY:
  - mem_req=1, mem_addr_sel=1, mem_we = (opCode == STORE).
  - STORE on ready: pc_wr=1, pc_sel=0, instret += 1, go to FETCH.
  - LOAD on ready: go to WRITEBACK.
  - Timeout: go to TRAP, cause 3.
- WRITEBACK (1 cycle):
  - ru_wr = (write_reg != 0).
  - ru_data_sel: 1 for LOAD, 2 for JAL/JALR, else 0.
  - pc_wr=1 (pc_sel per opcode). instret += 1. Go to FETCH.
- TRAP: absorbing. trap=1, all strobes 0, counters frozen. Only reset leaves TRAP.
- Counters wrap modulo 2^CNT_W.
- mem_ready while mem_req=0 is ignored.
- mem_ready in the same cycle the timeout would fire: completion wins.
- Reset mid-request drops mem_req immediately. No partial state survives.

Optional Feature:
- Macro: MCTRL_CYCLE_COUNT_EN.
- Defined: cycle_count increments every clock while reset is high and state != TRAP, and wraps.
- Undefined: cycle_count is tied to 0 and no counter flops are inferred.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), mem_ready on first request cycle -> states 0,1,2,4,0; ru_wr=1 only in WRITEBACK; instret=1 after 4 cycles.
- LW x5,0(x1), fetch ready after 2 wait cycles, data ready immediate -> FETCH held 3 cycles; mem_addr_sel 0 then 1; ru_data_sel=1 in WRITEBACK; total 7 cycles.
- BEQ taken (branch_taken=1) then not taken -> pc_wr=1 in EXECUTE with pc_sel=1 then 0; ru_wr never asserted.
- ADDI x0,x0,1 -> WRITEBACK with ru_wr=0, pc_wr=1, instret increments.
- Opcode 0x7F -> TRAP from DECODE, trap_cause=1; mem_ready=0 for MEM_TIMEOUT=16 cycles in FETCH -> trap_cause=2; strobes stay 0 until reset.
- Assert reset low mid-MEMORY of a store -> mem_req/mem_we drop asynchronously; after release, FETCH with instret=0 (and cycle_count=0 when MCTRL_CYCLE_COUNT_EN is defined).

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// over one unified memory port. Optional cycle counter enabled by `define MCTRL_CYCLE_COUNT_EN.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opCode,
  input  logic [2:0]       fun3,
  input  logic [6:0]       fun7,
  input  logic [4:0]       write_reg,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic [1:0]       pc_sel,
  output logic             ru_wr,
  output logic [1:0]       ru_data_sel,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEMORY    = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_TRAP      = 3'd7;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [2:0]        state_reg, state_next;
  logic [1:0]        cause_reg, cause_next;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [CNT_W-1:0]  instret_reg;
  logic              retire;
  logic              timeout;

  logic              is_load, is_store, is_branch, is_jal, is_jalr, is_jump, opcode_legal;
  logic [1:0]        alu_op_dec, pc_sel_dec, ru_data_sel_dec;
  logic              src_b_dec;

  logic              req_c, we_c, addr_sel_c, ir_wr_c, pc_wr_c, ru_wr_c, src_b_c;
  logic [1:0]        pc_sel_c, ru_data_sel_c, alu_op_c;

  // fun3/fun7 are decoded by the ALU control downstream when alu_op == 2
  logic unused_fields;
  assign unused_fields = ^{fun3, fun7};

  assign is_load   = (opCode == OP_LOAD);
  assign is_store  = (opCode == OP_STORE);
  assign is_branch = (opCode == OP_BRANCH);
  assign is_jal    = (opCode == OP_JAL);
  assign is_jalr   = (opCode == OP_JALR);
  assign is_jump   = is_jal | is_jalr;

  assign opcode_legal = (opCode == OP_R) | (opCode == OP_I) | is_load | is_store | is_branch |
                        is_jump | (opCode == OP_LUI) | (opCode == OP_AUIPC);

  assign pc_sel_dec      = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
  assign ru_data_sel_dec = is_load ? 2'd1 : (is_jump ? 2'd2 : 2'd0);

  always_comb begin
    alu_op_dec = 2'd0;
    src_b_dec  = 1'b0;
    case (opCode)
      OP_R:                       alu_op_dec = 2'd2;
      OP_I:      begin alu_op_dec = 2'd2; src_b_dec = 1'b1; end
      OP_LUI:    begin alu_op_dec = 2'd3; src_b_dec = 1'b1; end
      OP_AUIPC,
      OP_LOAD,
      OP_STORE:  begin alu_op_dec = 2'd0; src_b_dec = 1'b1; end
      OP_BRANCH:                  alu_op_dec = 2'd1;
      default: ;
    endcase
  end

  // Completion is tested before timeout, so a late ready still wins
  assign timeout = (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_next    = state_reg;
    cause_next    = cause_reg;
    retire        = 1'b0;
    req_c         = 1'b0;
    we_c          = 1'b0;
    addr_sel_c    = 1'b0;
    ir_wr_c       = 1'b0;
    pc_wr_c       = 1'b0;
    pc_sel_c      = 2'd0;
    ru_wr_c       = 1'b0;
    ru_data_sel_c = 2'd0;
    src_b_c       = 1'b0;
    alu_op_c      = 2'd0;
    case (state_reg)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          ir_wr_c    = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_TRAP;
          cause_next = 2'd2;
        end
      end
      S_DECODE: begin
        if (opcode_legal) begin
          state_next = S_EXECUTE;
        end else begin
          state_next = S_TRAP;
          cause_next = 2'd1;
        end
      end
      S_EXECUTE: begin
        alu_op_c = alu_op_dec;
        src_b_c  = src_b_dec;
        if (is_branch) begin
          pc_wr_c    = 1'b1;
          pc_sel_c   = branch_taken ? 2'd1 : 2'd0;
          retire     = 1'b1;
          state_next = S_FETCH;
        end else if (is_load | is_store) begin
          state_next = S_MEMORY;
        end else begin
          if (is_jump) begin
            pc_sel_c      = pc_sel_dec;
            ru_data_sel_c = 2'd2;
          end
          state_next = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        req_c      = 1'b1;
        addr_sel_c = 1'b1;
        we_c       = is_store;
        alu_op_c   = alu_op_dec;
        src_b_c    = src_b_dec;
        if (mem_ready) begin
          if (is_store) begin
            pc_wr_c    = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WRITEBACK;
          end
        end else if (timeout) begin
          state_next = S_TRAP;
          cause_next = 2'd3;
        end
      end
      S_WRITEBACK: begin
        alu_op_c      = alu_op_dec;
        src_b_c       = src_b_dec;
        ru_wr_c       = (write_reg != 5'd0);
        ru_data_sel_c = ru_data_sel_dec;
        pc_wr_c       = 1'b1;
        pc_sel_c      = pc_sel_dec;
        retire        = 1'b1;
        state_next    = S_FETCH;
      end
      S_TRAP: ;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_FETCH;
      cause_reg    <= 2'd0;
      wait_cnt_reg <= '0;
      instret_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      cause_reg  <= cause_next;
      if (retire) begin
        instret_reg <= instret_reg + CNT_W'(1);
      end
      if (state_next != state_reg) begin
        wait_cnt_reg <= '0;
      end else if (req_c && !mem_ready) begin
        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
      end
    end
  end

  // Gating with reset drops an in-flight request the instant reset falls
  assign mem_req      = reset & req_c;
  assign mem_we       = reset & we_c;
  assign mem_addr_sel = reset & addr_sel_c;
  assign ir_wr        = reset & ir_wr_c;
  assign pc_wr        = reset & pc_wr_c;
  assign ru_wr        = reset & ru_wr_c;
  assign alu_src_b    = reset & src_b_c;
  assign pc_sel       = reset ? pc_sel_c      : 2'd0;
  assign ru_data_sel  = reset ? ru_data_sel_c : 2'd0;
  assign alu_op       = reset ? alu_op_c      : 2'd0;

  assign state      = state_reg;
  assign trap       = (state_reg == S_TRAP);
  assign trap_cause = cause_reg;
  assign instret    = instret_reg;

`ifdef MCTRL_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cycle_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_reg <= '0;
    end else if (state_reg != S_TRAP) begin
      cycle_reg <= cycle_reg + CNT_W'(1);
    end
  end

  assign cycle_count = cycle_reg;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction class is expanded into an
// expected per-cycle trace of states, strobes and selects, then replayed against the DUT.
module tb_multicycle_controller;
  localparam int MT = 16;
  localparam int CW = 32;

  localparam int C_R = 0, C_I = 1, C_LOAD = 2, C_STORE = 3, C_BRANCH = 4;
  localparam int C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_ILL = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    opCode;
  logic [2:0]    fun3;
  logic [6:0]    fun7;
  logic [4:0]    write_reg;
  logic          branch_taken;
  logic          mem_ready;
  logic          mem_req, mem_we, mem_addr_sel, ir_wr, pc_wr, ru_wr, alu_src_b, trap;
  logic [1:0]    pc_sel, ru_data_sel, alu_op, trap_cause;
  logic [2:0]    state;
  logic [CW-1:0] instret, cycle_count;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opCode(opCode), .fun3(fun3), .fun7(fun7),
    .write_reg(write_reg), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_wr(ir_wr),
    .pc_wr(pc_wr), .pc_sel(pc_sel), .ru_wr(ru_wr), .ru_data_sel(ru_data_sel),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .trap(trap),
    .trap_cause(trap_cause), .instret(instret), .cycle_count(cycle_count)
  );

  typedef struct {
    logic       ready;
    logic [2:0] st;
    logic [9:0] ctl;
    logic       alu_chk;
    logic [1:0] alu;
    logic       srcb_chk;
    logic       srcb;
  } cyc_t;

  cyc_t          trace[$];
  int            total = 0;
  int            bad = 0;
  int            txn = 0;
  logic [CW-1:0] exp_instret = '0;
  logic [CW-1:0] exp_cycles = '0;
  logic [6:0]    illegal_op = 7'h7F;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s txn=%0d got=%0h exp=%0h t=%0t", tag, txn, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] op_of(input int cls);
    case (cls)
      C_R:      return 7'b0110011;
      C_I:      return 7'b0010011;
      C_LOAD:   return 7'b0000011;
      C_STORE:  return 7'b0100011;
      C_BRANCH: return 7'b1100011;
      C_JAL:    return 7'b1101111;
      C_JALR:   return 7'b1100111;
      C_LUI:    return 7'b0110111;
      C_AUIPC:  return 7'b0010111;
      default:  return illegal_op;
    endcase
  endfunction

  function automatic logic op_is_legal(input logic [6:0] op);
    for (int c = 0; c < C_ILL; c++) if (op_of(c) == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] exp_alu(input int cls);
    case (cls)
      C_R, C_I: return 2'd2;
      C_LUI:    return 2'd3;
      C_BRANCH: return 2'd1;
      default:  return 2'd0;
    endcase
  endfunction

  function automatic logic [9:0] mk(input logic req, input logic we, input logic asel,
                                    input logic irw, input logic pcw, input logic [1:0] pcs,
                                    input logic ruw, input logic [1:0] rds);
    return {req, we, asel, irw, pcw, pcs, ruw, rds};
  endfunction

  task automatic push(input logic rdy, input logic [2:0] st, input logic [9:0] ctl,
                      input logic achk, input logic [1:0] alu, input logic schk, input logic sb);
    cyc_t e;
    e.ready = rdy; e.st = st; e.ctl = ctl;
    e.alu_chk = achk; e.alu = alu; e.srcb_chk = schk; e.srcb = sb;
    trace.push_back(e);
  endtask

  // Expected trace for one instruction; fl/dl = wait cycles before ready (>= MT never completes)
  task automatic build_trace(input int cls, input logic [4:0] rd, input logic taken,
                             input int fl, input int dl, output int cause);
    logic       is_mem, is_jump, sb;
    logic [1:0] pcs, rds;
    trace.delete();
    cause = 0;
    for (int k = 0; k < ((fl >= MT) ? MT : fl + 1); k++)
      push(k == fl, 3'd0, mk(1, 0, 0, k == fl, 0, 2'd0, 0, 2'd0), 0, 2'd0, 0, 0);
    if (fl >= MT) begin cause = 2; return; end
    push(1'($urandom), 3'd1, 10'd0, 0, 2'd0, 0, 0);
    if (cls == C_ILL) begin cause = 1; return; end
    is_mem  = (cls == C_LOAD) || (cls == C_STORE);
    is_jump = (cls == C_JAL) || (cls == C_JALR);
    sb  = (cls == C_I) || (cls == C_LUI) || (cls == C_AUIPC) || is_mem;
    pcs = (cls == C_JAL) ? 2'd1 : ((cls == C_JALR) ? 2'd2 : 2'd0);
    if (cls == C_BRANCH)
      push(1'($urandom), 3'd2, mk(0, 0, 0, 0, 1, {1'b0, taken}, 0, 2'd0), 1, exp_alu(cls), 0, 0);
    else
      push(1'($urandom), 3'd2, mk(0, 0, 0, 0, 0, pcs, 0, is_jump ? 2'd2 : 2'd0),
           !is_jump, exp_alu(cls), !is_jump, sb);
    if (cls == C_BRANCH) return;
    if (is_mem) begin
      for (int k = 0; k < ((dl >= MT) ? MT : dl + 1); k++)
        push(k == dl, 3'd3, mk(1, cls == C_STORE, 1, 0, (cls == C_STORE) && (k == dl), 2'd0, 0, 2'd0),
             0, 2'd0, 0, 0);
      if (dl >= MT) begin cause = 3; return; end
      if (cls == C_STORE) return;
    end
    rds = (cls == C_LOAD) ? 2'd1 : (is_jump ? 2'd2 : 2'd0);
    push(1'($urandom), 3'd4, mk(0, 0, 0, 0, 1, pcs, rd != 5'd0, rds), 0, 2'd0, 0, 0);
  endtask

  task automatic run_cycle(input cyc_t e);
    mem_ready = e.ready;
    @(negedge clk);
    check_val("state", 32'(state), 32'(e.st));
    check_val("ctl", 32'({mem_req, mem_we, mem_addr_sel, ir_wr, pc_wr, pc_sel, ru_wr, ru_data_sel}),
              32'(e.ctl));
    if (e.alu_chk)  check_val("alu_op", 32'(alu_op), 32'(e.alu));
    if (e.srcb_chk) check_val("alu_src_b", 32'(alu_src_b), 32'(e.srcb));
    @(posedge clk);
    exp_cycles++;
    #1;
  endtask

  task automatic check_cycles(input string tag);
`ifdef MCTRL_CYCLE_COUNT_EN
    check_val(tag, cycle_count, exp_cycles);
`else
    check_val(tag, cycle_count, 32'd0);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_ctl", 32'({mem_req, mem_we, mem_addr_sel, ir_wr, pc_wr, pc_sel, ru_wr, ru_data_sel,
                              alu_src_b, alu_op}), 32'd0);
    check_val("rst_trap", 32'({trap, trap_cause}), 32'd0);
    check_val("rst_instret", instret, 32'd0);
    check_val("rst_cycles", cycle_count, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    mem_ready = 1'b0;
    exp_instret = '0;
    exp_cycles = '0;
  endtask

  task automatic run_txn(input int cls, input logic [4:0] rd, input logic taken,
                         input int fl, input int dl);
    int cause;
    build_trace(cls, rd, taken, fl, dl, cause);
    opCode = op_of(cls);
    fun3 = 3'($urandom);
    fun7 = 7'($urandom);
    write_reg = rd;
    branch_taken = taken;
    foreach (trace[i]) run_cycle(trace[i]);
    txn++;
    if (cause == 0) exp_instret++;
    $display("txn %0d cls=%0d op=%07b rd=%0d taken=%0d fl=%0d dl=%0d cycles=%0d cause=%0d",
             txn, cls, opCode, rd, taken, fl, dl, trace.size(), cause);
    check_val("end_state", 32'(state), (cause == 0) ? 32'd0 : 32'd7);
    check_val("trap", 32'(trap), (cause == 0) ? 32'd0 : 32'd1);
    check_val("trap_cause", 32'(trap_cause), 32'(cause));
    check_val("instret", instret, exp_instret);
    check_cycles("cycles");
    if (cause != 0) begin
      for (int k = 0; k < 4; k++) begin
        mem_ready = 1'($urandom);
        branch_taken = 1'($urandom);
        @(negedge clk);
        check_val("trap_ctl", 32'({mem_req, mem_we, mem_addr_sel, ir_wr, pc_wr, pc_sel, ru_wr,
                                   ru_data_sel}), 32'd0);
        check_val("trap_hold", 32'(state), 32'd7);
        @(posedge clk);
        #1;
      end
      check_val("trap_instret", instret, exp_instret);
      check_cycles("trap_cycles");
      do_reset();
    end
  endtask

  task automatic reset_mid_store();
    int cause;
    build_trace(C_STORE, 5'd0, 1'b0, 0, 3, cause);
    opCode = op_of(C_STORE);
    write_reg = 5'd0;
    for (int i = 0; i < 3; i++) run_cycle(trace[i]);
    mem_ready = 1'b0;
    @(negedge clk);
    check_val("mid_store_req", 32'({state, mem_req, mem_we}), 32'({3'd3, 1'b1, 1'b1}));
    #2;
    reset = 1'b0;
    #1;
    check_val("async_drop", 32'({state, mem_req, mem_we}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_instret = '0;
    exp_cycles = '0;
    #1;
    check_val("post_rst", 32'({state, mem_req, mem_addr_sel}), 32'({3'd0, 1'b1, 1'b0}));
    check_val("post_rst_instret", instret, 32'd0);
    check_val("post_rst_cycles", cycle_count, 32'd0);
    txn++;
    $display("txn %0d reset during store MEMORY", txn);
  endtask

  initial begin
    opCode = '0; fun3 = '0; fun7 = '0; write_reg = '0;
    branch_taken = 1'b0; mem_ready = 1'b0;
    do_reset();

    run_txn(C_R, 5'd3, 1'b0, 0, 0);
    run_txn(C_LOAD, 5'd5, 1'b0, 2, 0);
    run_txn(C_BRANCH, 5'd0, 1'b1, 0, 0);
    run_txn(C_BRANCH, 5'd0, 1'b0, 1, 0);
    run_txn(C_I, 5'd0, 1'b0, 0, 0);
    run_txn(C_R, 5'd7, 1'b0, MT - 1, 0);
    run_txn(C_STORE, 5'd0, 1'b0, 0, MT - 1);
    run_txn(C_JAL, 5'd1, 1'b0, 0, 0);
    run_txn(C_JALR, 5'd1, 1'b0, 1, 0);
    run_txn(C_LUI, 5'd9, 1'b0, 0, 0);
    run_txn(C_AUIPC, 5'd4, 1'b0, 0, 0);
    illegal_op = 7'h7F;
    run_txn(C_ILL, 5'd2, 1'b0, 0, 0);
    run_txn(C_R, 5'd3, 1'b0, MT, 0);
    run_txn(C_LOAD, 5'd5, 1'b0, 0, MT);
    reset_mid_store();

    for (int n = 0; n < 60; n++) begin
      int cls;
      cls = ($urandom_range(0, 15) == 0) ? C_ILL : int'($urandom_range(0, 8));
      if (cls == C_ILL) begin
        illegal_op = 7'h7F;
        for (int t = 0; t < 100; t++) begin
          illegal_op = 7'($urandom);
          if (!op_is_legal(illegal_op)) break;
        end
        if (op_is_legal(illegal_op)) illegal_op = 7'h7F;
      end
      run_txn(cls, 5'($urandom), 1'($urandom),
              ($urandom_range(0, 9) == 0) ? MT - 1 : int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
